// File: rtl/lsu_pkg.sv
// Shared load/store format codes, response codes and LSU FSM encoding.
package lsu_pkg;

    localparam logic [2:0] LF_LB  = 3'b000;
    localparam logic [2:0] LF_LH  = 3'b001;
    localparam logic [2:0] LF_LW  = 3'b010;
    localparam logic [2:0] LF_LD  = 3'b011;
    localparam logic [2:0] LF_LBU = 3'b100;
    localparam logic [2:0] LF_LHU = 3'b101;
    localparam logic [2:0] LF_LWU = 3'b110;
    localparam logic [2:0] LF_RSV = 3'b111;

    localparam logic [1:0] SF_SB = 2'b00;
    localparam logic [1:0] SF_SH = 2'b01;
    localparam logic [1:0] SF_SW = 2'b10;
    localparam logic [1:0] SF_SD = 2'b11;

    localparam logic [1:0] RESP_OK    = 2'b00;
    localparam logic [1:0] RESP_MISAL = 2'b01;
    localparam logic [1:0] RESP_TMO   = 2'b10;
    localparam logic [1:0] RESP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Byte-lane mask for an access size (0=byte .. 3=dword).
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one access: fmt = {unsigned, size[1:0]}, off = byte offset in the doubleword.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      fmt,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [7:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw   = mem_rdata >> {off, 3'b000};
        be    = size_mask(fmt[1:0]) << off;
        wdata = store_data << {off, 3'b000};

        case (fmt[1:0])
            2'd0: load_data = fmt[2] ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                     : {{(XLEN-8){raw[7]}}, raw[7:0]};
            2'd1: load_data = fmt[2] ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                     : {{(XLEN-16){raw[15]}}, raw[15:0]};
            2'd2: load_data = fmt[2] ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                     : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: load_data = raw;
        endcase

        case (fmt[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: one op at a time, IDLE -> REQ -> DONE, with timeout
// and misaligned/illegal detection before any bus access is made.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        load_format,
    input  logic [1:0]        store_format,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   load_data,
    output logic [1:0]        resp_err,
    output logic              stall
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        fmt_q, fmt_d;
    logic [2:0]        off_q, off_d;
    logic              load_q, load_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   ldata_q, ldata_d;
    logic [1:0]        err_q, err_d;

    logic            idle;
    logic            illegal;
    logic [2:0]      op_fmt;
    logic [2:0]      a_fmt, a_off;
    logic [7:0]      a_be;
    logic [XLEN-1:0] a_wdata, a_load;
    logic            a_mis;

    assign idle    = (state_q == ST_IDLE);
    assign op_fmt  = in_load ? load_format : {1'b0, store_format};
    assign illegal = (in_load == in_store) | (in_load & (load_format == LF_RSV));

    // In IDLE the aligner sees the incoming op; afterwards it sees the captured op
    // so load extraction uses the format/offset of the access in flight.
    assign a_fmt = idle ? op_fmt    : fmt_q;
    assign a_off = idle ? addr[2:0] : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .fmt        (a_fmt),
        .off        (a_off),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .be         (a_be),
        .wdata      (a_wdata),
        .load_data  (a_load),
        .misaligned (a_mis)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fmt_d   = fmt_q;
        off_d   = off_q;
        load_d  = load_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    fmt_d   = op_fmt;
                    off_d   = addr[2:0];
                    load_d  = in_load;
                    we_d    = in_store;
                    addr_d  = {addr[ADDR_W-1:3], 3'b000};
                    be_d    = a_be;
                    wdata_d = a_wdata;
                    ldata_d = '0;
                    cnt_d   = '0;
                    if (illegal) begin
                        state_d = ST_DONE;
                        err_d   = RESP_ILL;
                    end else if (a_mis) begin
                        state_d = ST_DONE;
                        err_d   = RESP_MISAL;
                    end else begin
                        state_d = ST_REQ;
                        err_d   = RESP_OK;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack on the last allowed cycle wins over the timeout.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    err_d   = RESP_OK;
                    if (load_q) ldata_d = a_load;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = RESP_TMO;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fmt_q   <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            err_q   <= RESP_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fmt_q   <= fmt_d;
            off_q   <= off_d;
            load_q  <= load_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = idle;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign out_valid = (state_q == ST_DONE);
    assign load_data = ldata_q;
    assign resp_err  = err_q;
    assign stall     = (in_valid & ~in_ready) | ~idle;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed vector bench for lsu_mem_initiator: per-op table plus reset/stale-ack sequences.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_load, in_store;
    logic [2:0]  load_format;
    logic [1:0]  store_format;
    logic [63:0] addr, store_data;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, load_data;
    logic [7:0]  mem_be;
    logic        out_valid, stall;
    logic [1:0]  resp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.XLEN(64), .ADDR_W(64), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_store(in_store),
        .load_format(load_format), .store_format(store_format),
        .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .load_data(load_data),
        .resp_err(resp_err), .stall(stall)
    );

    typedef struct {
        string       name;
        logic        ld, st;
        logic [2:0]  lf;
        logic [1:0]  sf;
        logic [63:0] addr, sdata, rdata;
        int          k;       // ack after k extra REQ cycles; -1 = never
        logic [7:0]  be;
        logic [63:0] wdata;
        int          nreq;    // expected mem_req cycles (0 = no bus access)
        logic [1:0]  err;
        logic [63:0] ldata;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int  nreq  = 0;
        bit  done  = 0;
        bit  first = 1;
        @(negedge clk);
        in_valid = 1'b1; in_load = v.ld; in_store = v.st;
        load_format = v.lf; store_format = v.sf;
        addr = v.addr; store_data = v.sdata;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (out_valid) begin
                done    = 1;
                mem_ack = 1'b0;
                chk({v.name, " resp_err"}, 64'(resp_err), 64'(v.err));
                chk({v.name, " load_data"}, load_data, v.ldata);
                chk({v.name, " req_cycles"}, 64'(nreq), 64'(v.nreq));
                chk({v.name, " latency"}, 64'(c), 64'((v.nreq == 0) ? 1 : v.nreq + 1));
                chk({v.name, " in_ready_done"}, 64'(in_ready), 64'(0));
            end else begin
                if (mem_req) begin
                    nreq++;
                    if (first) begin
                        first = 0;
                        chk({v.name, " mem_be"}, 64'(mem_be), 64'(v.be));
                        chk({v.name, " mem_wdata"}, mem_wdata, v.wdata);
                        chk({v.name, " mem_addr"}, mem_addr, v.addr & ~64'h7);
                        chk({v.name, " mem_we"}, 64'(mem_we), 64'(v.st));
                        chk({v.name, " stall"}, 64'(stall), 64'(1));
                    end
                    mem_ack   = (nreq == v.k + 1);
                    mem_rdata = v.rdata;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no out_valid within 40 cycles, expected one", v.name);
        end
        @(negedge clk);
        chk({v.name, " after_done"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        bit seen;
        //           name          ld   st   lf      sf     addr          sdata                  rdata                  k   be     wdata                  nreq err    ldata
        vecs[0]  = '{"sd",       0, 1, 3'b000, 2'b11, 64'h1000, 64'h1122334455667788, 64'hFFFFFFFFFFFFFFFF, 2, 8'hFF, 64'h1122334455667788, 3, 2'b00, 64'h0};
        vecs[1]  = '{"lb",       1, 0, 3'b000, 2'b00, 64'h1003, 64'h0, 64'h0000000080000000, 0, 8'h08, 64'h0, 1, 2'b00, 64'hFFFFFFFFFFFFFF80};
        vecs[2]  = '{"lbu",      1, 0, 3'b100, 2'b00, 64'h1003, 64'h0, 64'h0000000080000000, 0, 8'h08, 64'h0, 1, 2'b00, 64'h80};
        vecs[3]  = '{"sh",       0, 1, 3'b000, 2'b01, 64'h1006, 64'hBEEF, 64'hFFFFFFFFFFFFFFFF, 1, 8'hC0, 64'hBEEF000000000000, 2, 2'b00, 64'h0};
        vecs[4]  = '{"lw",       1, 0, 3'b010, 2'b00, 64'h1004, 64'h0, 64'hDEADBEEF00000000, 0, 8'hF0, 64'h0, 1, 2'b00, 64'hFFFFFFFFDEADBEEF};
        vecs[5]  = '{"lw_misal", 1, 0, 3'b010, 2'b00, 64'h1002, 64'h0, 64'h0, -1, 8'h00, 64'h0, 0, 2'b01, 64'h0};
        vecs[6]  = '{"ld_and_st",1, 1, 3'b011, 2'b11, 64'h1000, 64'h0, 64'h0, -1, 8'h00, 64'h0, 0, 2'b11, 64'h0};
        vecs[7]  = '{"lh",       1, 0, 3'b001, 2'b00, 64'h1002, 64'h0, 64'h00000000ABCD0000, 0, 8'h0C, 64'h0, 1, 2'b00, 64'hFFFFFFFFFFFFABCD};
        vecs[8]  = '{"lhu",      1, 0, 3'b101, 2'b00, 64'h1002, 64'h0, 64'h00000000ABCD0000, 0, 8'h0C, 64'h0, 1, 2'b00, 64'h000000000000ABCD};
        vecs[9]  = '{"sb",       0, 1, 3'b000, 2'b00, 64'h1005, 64'hAB, 64'hFFFFFFFFFFFFFFFF, 0, 8'h20, 64'h0000AB0000000000, 1, 2'b00, 64'h0};
        vecs[10] = '{"lwu",      1, 0, 3'b110, 2'b00, 64'h1004, 64'h0, 64'hDEADBEEF00000000, 0, 8'hF0, 64'h0, 1, 2'b00, 64'h00000000DEADBEEF};
        vecs[11] = '{"ld",       1, 0, 3'b011, 2'b00, 64'h2008, 64'h0, 64'h0123456789ABCDEF, 3, 8'hFF, 64'h0, 4, 2'b00, 64'h0123456789ABCDEF};
        vecs[12] = '{"lf_rsv",   1, 0, 3'b111, 2'b00, 64'h1000, 64'h0, 64'h0, -1, 8'h00, 64'h0, 0, 2'b11, 64'h0};
        vecs[13] = '{"no_op",    0, 0, 3'b000, 2'b00, 64'h1000, 64'h0, 64'h0, -1, 8'h00, 64'h0, 0, 2'b11, 64'h0};
        vecs[14] = '{"sd_misal", 0, 1, 3'b000, 2'b11, 64'h1004, 64'h55, 64'h0, -1, 8'h00, 64'h0, 0, 2'b01, 64'h0};
        vecs[15] = '{"sw_hi",    0, 1, 3'b000, 2'b10, 64'h100C, 64'hFFFFFFFF12345678, 64'hFFFFFFFFFFFFFFFF, 0, 8'hF0, 64'h1234567800000000, 1, 2'b00, 64'h0};
        vecs[16] = '{"ack_last", 1, 0, 3'b011, 2'b00, 64'h1000, 64'h0, 64'hCAFEF00D12345678, 15, 8'hFF, 64'h0, 16, 2'b00, 64'hCAFEF00D12345678};
        vecs[17] = '{"timeout",  1, 0, 3'b011, 2'b00, 64'h1000, 64'h0, 64'h0, -1, 8'hFF, 64'h0, 16, 2'b10, 64'h0};

        rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        load_format = '0; store_format = '0; addr = '0; store_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready", 64'(in_ready), 64'(1));
        chk("rst req_we_ov_stall", 64'({mem_req, mem_we, out_valid, stall}), 64'(0));
        chk("rst mem_addr", mem_addr, 64'h0);
        chk("rst mem_be", 64'(mem_be), 64'h0);
        chk("rst mem_wdata", mem_wdata, 64'h0);
        chk("rst load_data", load_data, 64'h0);
        chk("rst resp_err", 64'(resp_err), 64'(0));

        for (int i = 0; i < 18; i++) do_op(vecs[i]);

        // Stale ack in IDLE after the timeout must be ignored.
        mem_ack = 1'b1; mem_rdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stale_ack req_ov_rdy", 64'({mem_req, out_valid, in_ready}), 64'(3'b001));
        @(negedge clk);
        chk("stale_ack ov", 64'(out_valid), 64'(0));
        chk("stale_ack load_data", load_data, 64'h0);

        // Reset in the middle of REQ aborts the op with no out_valid.
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
        load_format = 3'b011; addr = 64'h3000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort req_up", 64'(mem_req), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort req_ov_rdy", 64'({mem_req, out_valid, in_ready}), 64'(3'b001));
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || mem_req) seen = 1;
        end
        chk("abort quiet", 64'(seen), 64'(0));

        do_op('{"ld_after_rst", 1, 0, 3'b011, 2'b00, 64'h3000, 64'h0, 64'h8877665544332211, 1, 8'hFF, 64'h0, 2, 2'b00, 64'h8877665544332211});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
